// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   state_t   : FSM encoding (IDLE = no word held, HOLD = word presented downstream)
//   SRC0..3   : source index constants used as mux control values
//   mux4_bit  : one bit-slice of the 4:1 datapath mux
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] SRC0 = 2'd0;
    localparam logic [1:0] SRC1 = 2'd1;
    localparam logic [1:0] SRC2 = 2'd2;
    localparam logic [1:0] SRC3 = 2'd3;

    // Single-bit 4:1 multiplexer; the datapath is built from WIDTH of these.
    function automatic logic mux4_bit(input logic d0, input logic d1,
                                      input logic d2, input logic d3,
                                      input logic [1:0] s);
        logic r;
        case (s)
            SRC0:    r = d0;
            SRC1:    r = d1;
            SRC2:    r = d2;
            SRC3:    r = d3;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four producers, the arbiter and the single consumer.
//   req/din0..din3 : producer side requests and words
//   grant          : one-hot capture strobe back to the producers
//   out_valid/out_ready/out_data : downstream valid/ready handshake
//   sel            : index of the last winner (drives slave datapaths)
// slave modport = arbiter view, master modport = producer/consumer view.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 8);
    logic [3:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [3:0]       grant;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;

    modport slave (
        input  req, din0, din1, din2, din3, out_ready,
        output grant, out_valid, out_data, sel
    );

    modport master (
        output req, din0, din1, din2, din3, out_ready,
        input  grant, out_valid, out_data, sel
    );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority encoder.
//   req    : request vector
//   ptr    : index holding highest priority
//   any    : at least one request present
//   winner : first requesting index searching ptr, ptr+1, ... mod 4
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] winner
);

    logic [1:0] idx_s;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        any    = |req;
        winner = ptr;
        idx_s  = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx_s = ptr + 2'(k);
            if (req[idx_s]) begin
                winner = idx_s;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 4:1 mux between four requesters.
// The winning word is captured into out_data and presented with valid/ready;
// a new word may be captured in the same cycle the previous one is taken.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave view of mux4_rr_arbiter_if (req, din0..3, grant,
//           out_valid, out_ready, out_data, sel)
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    mux4_rr_arbiter_if.slave    bus
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       ptr_r;
    logic [1:0]       sel_r;
    logic [WIDTH-1:0] data_r;
    logic             any_s;
    logic [1:0]       winner_s;
    logic             take_s;
    logic [3:0]       grant_s;
    logic [WIDTH-1:0] mux_s;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (ptr_r),
        .any    (any_s),
        .winner (winner_s)
    );

    // Bit-sliced 4:1 datapath mux steered by the current winner.
    for (genvar k = 0; k < WIDTH; k++) begin : g_mux
        assign mux_s[k] = mux4_bit(bus.din0[k], bus.din1[k], bus.din2[k], bus.din3[k], winner_s);
    end

    // Capture decision and one-hot grant; reset gates grant so nothing is issued while held.
    always_comb begin
        take_s  = 1'b0;
        grant_s = 4'b0000;
        if (!reset && any_s && ((state_r == ST_IDLE) || bus.out_ready)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            grant_s = 4'b0001 << winner_s;
        end else begin
            grant_s = 4'b0000;
        end
    end

    // Next-state logic: HOLD persists while stalled or while refilled on a take.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) state_nxt_s = ST_HOLD;
                else        state_nxt_s = ST_IDLE;
            end
            ST_HOLD: begin
                if (take_s)             state_nxt_s = ST_HOLD;
                else if (bus.out_ready) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and pointer registers; only a take changes them, so a stall freezes all.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r <= '0;
            sel_r  <= 2'd0;
            ptr_r  <= 2'd0;
        end else if (take_s) begin
            data_r <= mux_s;
            sel_r  <= winner_s;
            ptr_r  <= winner_s + 2'd1;
        end
    end

    assign bus.grant     = grant_s;
    assign bus.out_valid = (state_r == ST_HOLD);
    assign bus.out_data  = data_r;
    assign bus.sel       = sel_r;

endmodule
